axis_rr_arbiter: RTL and testbench
==================================

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of AXI-Stream source ports (2..8).
REQ-002 Parameter DATA_W, default 32: tdata width in bits.
REQ-003 aclk  input  1  single clock; all logic on rising edge.
REQ-004 areset  input  1  reset, synchronous, active-high.
REQ-005 s_tvalid  input  N_SRC  per-source valid.
REQ-006 s_tready  output  N_SRC  per-source ready.
REQ-007 s_tdata  input  N_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-008 s_tlast  input  N_SRC  per-source end-of-packet.
REQ-009 m_tvalid  output  1  shared-sink valid.
REQ-010 m_tready  input  1  shared-sink ready.
REQ-011 m_tdata  output  DATA_W  shared-sink data.
REQ-012 m_tlast  output  1  shared-sink end-of-packet.
REQ-013 grant  output  N_SRC  one-hot owner of the sink; all-zero when idle.
REQ-014 pkt_cnt  output  16  count of packets completed on the sink.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and LOCK.
REQ-016 In IDLE: m_tvalid=0, all s_tready=0, grant=0.
REQ-017 In IDLE with any s_tvalid high: register the winner into sel/grant and enter LOCK on the next edge (one-cycle arbitration latency).
REQ-018 Winner = first requesting index strictly after last_grant, scanning upward modulo N_SRC (round-robin).
REQ-019 In LOCK: m_tvalid, m_tdata and m_tlast SHALL equal the s_* signals of source sel combinationally.
REQ-020 In LOCK: s_tready[sel]=m_tready; every other s_tready=0.
REQ-021 Transfer = m_tvalid & m_tready; no other condition advances data.
REQ-022 A transfer with m_tlast=1 in LOCK SHALL set last_grant=sel, increment pkt_cnt and return to IDLE. This leaves one idle bubble cycle between packets.
REQ-023 Ownership SHALL NOT change mid-packet.
- If s_tvalid[sel] drops mid-packet, the block SHALL stay in LOCK.
- m_tvalid then follows s_tvalid[sel] low.
REQ-024 A requester that raises s_tvalid while another source is locked SHALL wait; it SHALL NOT be dropped.
REQ-025 With all N_SRC requesting continuously, each source SHALL receive exactly one packet per N_SRC grants.
REQ-026 Single-beat packets (tlast on the first beat) SHALL be legal: LOCK lasts one handshake cycle.
REQ-027 pkt_cnt SHALL wrap from 16'hFFFF to 0.

Reset
REQ-028 While areset=1 at a rising edge, the block SHALL force:
- state=IDLE, grant=0, sel=0;
- last_grant=N_SRC-1, so source 0 wins first;
- pkt_cnt=0.
REQ-029 During reset: m_tvalid=0 and all s_tready=0.
REQ-030 Reset asserted mid-packet SHALL abort the packet.
- No further beats are forwarded.
- After reset release, arbitration restarts from source 0.

Structure
REQ-031 Shared package axis_pkg SHALL hold:
- default N_SRC and DATA_W constants;
- the arb_state_t enum (IDLE, LOCK).
REQ-032 Sub-module rr_pick SHALL contain the round-robin priority pick.
- Purely combinational.
- Inputs: req[N_SRC], last[idx].
- Outputs: any, idx, onehot.
REQ-033 Only state, sel, grant, last_grant and pkt_cnt SHALL be registered. The datapath mux is combinational.

Verification
REQ-034 Reset, then s_tvalid=4'b0001 with a 3-beat packet AAAA_0001..0003 and m_tready=1:
- grant=0001 one cycle after the request;
- three beats forwarded in order, tlast on the third beat;
- IDLE next; pkt_cnt=1.
REQ-035 All four sources each hold one 2-beat packet at the same time:
- grant order is 0,1,2,3;
- each packet is contiguous on m_tdata;
- pkt_cnt=4.
REQ-036 Source 2 locked; m_tready toggles 1,0,1,0; s_tvalid[2] drops for 2 cycles mid-packet:
- grant stays 0100;
- no beat is lost or duplicated;
- s_tready[2] mirrors m_tready.
REQ-037 Source 1 is mid-packet (beat 2 of 4) when source 0 requests:
- source 1 finishes all 4 beats first;
- source 0 is granted after the bubble.
REQ-038 areset pulsed during beat 2 of a source-3 packet:
- m_tvalid=0 the cycle after;
- pkt_cnt=0;
- the next request from sources 3 and 0 together grants source 0.
REQ-039 Preload pkt_cnt with 16'hFFFF via 65535 single-beat packets, then send one more packet: pkt_cnt=0.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared constants and state encoding for the AXI-Stream
// round-robin arbiter.
package axis_pkg;

    localparam int N_SRC_DEF  = 4;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first requester strictly after
// the previous owner, scanning upward modulo N_SRC.
module rr_pick
    import axis_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N_SRC-1:0] onehot
);

    // Scan farthest-first so the nearest requester wins.
    always_comb begin
        int c;
        c   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            c = (int'(last) + k) % N_SRC;
            if (req[c]) begin
                any = 1'b1;
                idx = IDX_W'(c);
            end
        end
    end

    assign onehot = any ? (N_SRC'(1) << idx) : '0;

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter; a source keeps the sink
// from its first beat until its tlast handshake.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int N_SRC  = N_SRC_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [N_SRC-1:0]        s_tvalid,
    output logic [N_SRC-1:0]        s_tready,
    input  logic [N_SRC*DATA_W-1:0] s_tdata,
    input  logic [N_SRC-1:0]        s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tlast,
    output logic [N_SRC-1:0]        grant,
    output logic [15:0]             pkt_cnt
);

    localparam int IDX_W = $clog2(N_SRC);

    arb_state_t       state, state_nx;
    logic [IDX_W-1:0] sel, sel_nx;
    logic [IDX_W-1:0] last_grant, last_nx;
    logic [N_SRC-1:0] grant_nx;
    logic [15:0]      pkt_cnt_q, cnt_nx;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [N_SRC-1:0] pick_oh;
    logic             lock, xfer, done;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (s_tvalid),
        .last   (last_grant),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    // Reset silences the sink immediately, not only after the edge.
    assign lock = (state == LOCK) && !areset;

    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        s_tready = '0;
        if (lock) begin
            m_tvalid      = s_tvalid[sel];
            m_tdata       = s_tdata[sel*DATA_W +: DATA_W];
            m_tlast       = s_tlast[sel];
            s_tready[sel] = m_tready;
        end
    end

    assign xfer = m_tvalid & m_tready;
    assign done = xfer & m_tlast;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        grant_nx = grant;
        last_nx  = last_grant;
        cnt_nx   = pkt_cnt_q;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = LOCK;
                    sel_nx   = pick_idx;
                    grant_nx = pick_oh;
                end
            end
            LOCK: begin
                if (done) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                    last_nx  = sel;
                    cnt_nx   = pkt_cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            sel        <= '0;
            grant      <= '0;
            last_grant <= IDX_W'(N_SRC - 1);
            pkt_cnt_q  <= '0;
        end else begin
            state      <= state_nx;
            sel        <= sel_nx;
            grant      <= grant_nx;
            last_grant <= last_nx;
            pkt_cnt_q  <= cnt_nx;
        end
    end

    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus random
// traffic checked cycle by cycle against an ownership model.
module tb_axis_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           aclk = 1'b0;
    logic           areset;
    logic [N-1:0]   s_tvalid, s_tready, s_tlast;
    logic [N*W-1:0] s_tdata;
    logic           m_tvalid, m_tready, m_tlast;
    logic [W-1:0]   m_tdata;
    logic [N-1:0]   grant;
    logic [15:0]    pkt_cnt;

    axis_rr_arbiter #(.N_SRC(N), .DATA_W(W)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .grant    (grant),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    typedef struct {
        int           src;
        logic [W-1:0] d;
        logic         l;
    } xfer_t;

    beat_t srcq [N][$];
    xfer_t sink_log[$];
    xfer_t exp_log[$];
    int    grant_log[$];
    int    exp_grants[$];

    int          checks = 0;
    int          errors = 0;
    // Model: current owner (-1 when nobody owns the sink), previous owner, count
    int          own;
    int          lastg;
    logic [15:0] cnt;

    logic [N-1:0] en;
    int           rdy_mode;
    int           popped[N];
    logic [N-1:0] prev_grant;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int idx_of(logic [N-1:0] g);
        for (int i = 0; i < N; i++)
            if (g[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] pk(int s, logic l, logic [W-1:0] d);
        return {24'd0, 4'(s), 3'd0, l, d};
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++)
            if (srcq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_pkt(int s, int len, logic [W-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = base + W'(k);
            b.l = (k == len - 1);
            srcq[s].push_back(b);
        end
    endtask

    task automatic exp_pkt(int s, int len, logic [W-1:0] base);
        xfer_t x;
        for (int k = 0; k < len; k++) begin
            x.src = s;
            x.d   = base + W'(k);
            x.l   = (k == len - 1);
            exp_log.push_back(x);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && en[i]) begin
                s_tvalid[i]         = 1'b1;
                s_tdata[i*W +: W]   = srcq[i][0].d;
                s_tlast[i]          = srcq[i][0].l;
            end else begin
                s_tvalid[i]         = 1'b0;
                s_tdata[i*W +: W]   = W'($urandom);
                s_tlast[i]          = 1'($urandom);
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    // One clock: check at negedge, advance model and sources at posedge.
    task automatic cycle();
        logic         exp_v;
        logic [N-1:0] exp_rdy, exp_g, fire_s, sv_c;
        logic         rst_c, mv, ml;
        xfer_t        x;
        @(negedge aclk);
        exp_v   = (own >= 0 && !areset) ? s_tvalid[own] : 1'b0;
        exp_rdy = (own >= 0 && !areset && m_tready) ? (N'(1) << own) : '0;
        exp_g   = (own >= 0) ? (N'(1) << own) : '0;
        chk("m_tvalid", 64'(m_tvalid), 64'(exp_v));
        chk("s_tready", 64'(s_tready), 64'(exp_rdy));
        chk("grant", 64'(grant), 64'(exp_g));
        chk("pkt_cnt", 64'(pkt_cnt), 64'(cnt));
        if (exp_v) begin
            chk("m_tdata", 64'(m_tdata), 64'(s_tdata[own*W +: W]));
            chk("m_tlast", 64'(m_tlast), 64'(s_tlast[own]));
        end
        if (m_tvalid && m_tready) begin
            x.src = idx_of(grant);
            x.d   = m_tdata;
            x.l   = m_tlast;
            sink_log.push_back(x);
        end
        if (grant != 0 && prev_grant == 0)
            grant_log.push_back(idx_of(grant));
        prev_grant = grant;
        fire_s = s_tvalid & s_tready;
        sv_c   = s_tvalid;
        rst_c  = areset;
        mv     = exp_v && m_tready;
        ml     = (own >= 0) ? s_tlast[own] : 1'b0;
        @(posedge aclk);
        for (int i = 0; i < N; i++)
            if (fire_s[i] && srcq[i].size() > 0) begin
                void'(srcq[i].pop_front());
                popped[i]++;
            end
        if (rst_c) begin
            own   = -1;
            lastg = N - 1;
            cnt   = 16'd0;
        end else if (own < 0) begin
            for (int k = 1; k <= N; k++)
                if (own < 0 && sv_c[(lastg + k) % N])
                    own = (lastg + k) % N;
        end else if (mv && ml) begin
            lastg = own;
            own   = -1;
            cnt   = cnt + 16'd1;
        end
        #1;
    endtask

    task automatic run_drain(int budget);
        int n;
        n = 0;
        do begin
            drive();
            cycle();
            n++;
        end while (!(all_empty() && own < 0) && n < budget);
        chk("drain_done", 64'(all_empty() && own < 0), 64'd1);
    endtask

    task automatic clear_logs();
        sink_log.delete();
        exp_log.delete();
        grant_log.delete();
        exp_grants.delete();
        for (int i = 0; i < N; i++) popped[i] = 0;
    endtask

    task automatic cmp_logs(string nm);
        chk({nm, "_len"}, 64'(sink_log.size()), 64'(exp_log.size()));
        for (int k = 0; k < exp_log.size() && k < sink_log.size(); k++)
            chk({nm, "_beat"},
                pk(sink_log[k].src, sink_log[k].l, sink_log[k].d),
                pk(exp_log[k].src, exp_log[k].l, exp_log[k].d));
        chk({nm, "_glen"}, 64'(grant_log.size()), 64'(exp_grants.size()));
        for (int k = 0; k < exp_grants.size() && k < grant_log.size(); k++)
            chk({nm, "_gnt"}, 64'(grant_log[k]), 64'(exp_grants[k]));
    endtask

    task automatic do_reset();
        en       = '1;
        rdy_mode = 0;
        areset   = 1'b1;
        drive();
        cycle();
        areset = 1'b0;
        for (int i = 0; i < N; i++) srcq[i].delete();
        clear_logs();
    endtask

    initial begin
        int  drops;
        bit  pushed;
        int  s, len, n;
        areset     = 1'b1;
        en         = '1;
        rdy_mode   = 0;
        m_tready   = 1'b1;
        own        = -1;
        lastg      = N - 1;
        cnt        = 16'd0;
        prev_grant = '0;
        s_tvalid   = '0;
        s_tlast    = '0;
        s_tdata    = '0;
        clear_logs();
        drive();
        @(posedge aclk);
        #1;
        cycle();
        areset = 1'b0;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_cnt", 64'(pkt_cnt), 64'd0);
        chk("rst_mvalid", 64'(m_tvalid), 64'd0);

        // Single 3-beat packet from source 0
        push_pkt(0, 3, 32'hAAAA_0001);
        drive();
        chk("t1_grant_pre", 64'(grant), 64'd0);
        cycle();
        chk("t1_grant", 64'(grant), 64'b0001);
        run_drain(50);
        exp_pkt(0, 3, 32'hAAAA_0001);
        exp_grants.push_back(0);
        cmp_logs("t1");
        chk("t1_cnt", 64'(pkt_cnt), 64'd1);

        // All four sources contend with 2-beat packets
        do_reset();
        for (int i = 0; i < N; i++) push_pkt(i, 2, 32'hB000_0000 + 32'(i * 16));
        run_drain(100);
        for (int i = 0; i < N; i++) begin
            exp_pkt(i, 2, 32'hB000_0000 + 32'(i * 16));
            exp_grants.push_back(i);
        end
        cmp_logs("t2");
        chk("t2_cnt", 64'(pkt_cnt), 64'd4);

        // Source 2 with toggling sink ready and a 2-cycle valid gap
        do_reset();
        rdy_mode = 1;
        m_tready = 1'b0;
        push_pkt(2, 4, 32'hC000_0000);
        drops = 0;
        n     = 0;
        do begin
            if (popped[2] >= 2 && drops < 2 && own == 2) begin
                en[2] = 1'b0;
                drops++;
            end else begin
                en[2] = 1'b1;
            end
            drive();
            cycle();
            n++;
        end while (!(all_empty() && own < 0) && n < 60);
        chk("t3_drained", 64'(all_empty() && own < 0), 64'd1);
        exp_pkt(2, 4, 32'hC000_0000);
        exp_grants.push_back(2);
        cmp_logs("t3");

        // Source 0 arrives while source 1 is mid-packet
        do_reset();
        push_pkt(1, 4, 32'hD100_0000);
        pushed = 1'b0;
        n      = 0;
        do begin
            if (popped[1] == 2 && !pushed) begin
                push_pkt(0, 2, 32'hD000_0000);
                pushed = 1'b1;
            end
            drive();
            cycle();
            n++;
        end while (!(pushed && all_empty() && own < 0) && n < 60);
        chk("t4_drained", 64'(all_empty() && own < 0), 64'd1);
        exp_pkt(1, 4, 32'hD100_0000);
        exp_pkt(0, 2, 32'hD000_0000);
        exp_grants.push_back(1);
        exp_grants.push_back(0);
        cmp_logs("t4");
        chk("t4_cnt", 64'(pkt_cnt), 64'd2);

        // Reset aborts a source-3 packet after its second beat
        clear_logs();
        push_pkt(3, 4, 32'hE300_0000);
        n = 0;
        do begin
            drive();
            cycle();
            n++;
        end while (popped[3] < 2 && n < 30);
        chk("t5_two_beats", 64'(sink_log.size()), 64'd2);
        areset = 1'b1;
        drive();
        cycle();
        areset = 1'b0;
        srcq[3].delete();
        drive();
        chk("t5_mvalid_after", 64'(m_tvalid), 64'd0);
        chk("t5_cnt", 64'(pkt_cnt), 64'd0);
        clear_logs();
        push_pkt(3, 2, 32'hE310_0000);
        push_pkt(0, 2, 32'hE000_0000);
        run_drain(60);
        exp_pkt(0, 2, 32'hE000_0000);
        exp_pkt(3, 2, 32'hE310_0000);
        exp_grants.push_back(0);
        exp_grants.push_back(3);
        cmp_logs("t5");

        // Continuous contention: strict rotation
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                push_pkt(i, 1 + ((i + r) % 3), 32'hF000_0000 + 32'(r * 256 + i * 16));
        run_drain(200);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) begin
                exp_pkt(i, 1 + ((i + r) % 3), 32'hF000_0000 + 32'(r * 256 + i * 16));
                exp_grants.push_back(i);
            end
        cmp_logs("t6");

        // Random traffic, gaps and backpressure
        do_reset();
        rdy_mode = 2;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = $urandom_range(0, N - 1);
                if (srcq[s].size() < 8) begin
                    len = $urandom_range(1, 4);
                    push_pkt(s, len, W'($urandom));
                end
            end
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 4) != 0);
            drive();
            cycle();
        end
        en       = '1;
        rdy_mode = 0;
        run_drain(3000);

        // Counter wrap: preload near the top, then two more packets
        force dut.pkt_cnt_q = 16'hFFFE;
        cnt = 16'hFFFE;
        drive();
        cycle();
        release dut.pkt_cnt_q;
        push_pkt(1, 1, 32'h1234_0001);
        run_drain(20);
        chk("t7_cnt_ffff", 64'(pkt_cnt), 64'hFFFF);
        push_pkt(2, 1, 32'h1234_0002);
        run_drain(20);
        chk("t7_cnt_wrap", 64'(pkt_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
